// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send handshake, LSB-first shifting
// on device clock falls, acknowledge check and per-phase timeouts.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned START_TIMEOUT  = 750000,
  parameter int unsigned BIT_TIMEOUT    = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       PS2_KBCLK_IN,
  input  logic       PS2_KBDAT_IN,
  output logic       PS2_KBCLK_OE,
  output logic       PS2_KBDAT_OE
);

  localparam int unsigned MAX_AB  = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
  localparam int unsigned CNT_MAX = (MAX_AB > BIT_TIMEOUT) ? MAX_AB : BIT_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] INHIBIT   = 3'd1;
  localparam logic [2:0] RTS       = 3'd2;
  localparam logic [2:0] DATA      = 3'd3;
  localparam logic [2:0] PARITY    = 3'd4;
  localparam logic [2:0] STOP      = 3'd5;
  localparam logic [2:0] WAIT_IDLE = 3'd6;
  localparam logic [2:0] ERR       = 3'd7;

  logic [2:0]       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [2:0]       idx, idx_n;
  logic [7:0]       byte_q, byte_n;
  logic             par_q, par_n;
  logic             clk_oe_n, dat_oe_n, done_n, err_n;
  logic             kbclk_meta, kbclk_sync, kbclk_sync_d;
  logic             kbdat_meta, kbdat_sync;
  logic             fall;
  logic             bit_to;

  assign fall    = kbclk_sync_d & ~kbclk_sync;
  assign cnt_inc = (cnt == CNT_W'(CNT_MAX)) ? cnt : cnt + CNT_W'(1);
  assign bit_to  = (cnt >= CNT_W'(BIT_TIMEOUT - 1));

  // Next-state and next-output logic; every OE change is registered.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt_inc;
    idx_n    = idx;
    byte_n   = byte_q;
    par_n    = par_q;
    clk_oe_n = 1'b0;
    dat_oe_n = PS2_KBDAT_OE;
    done_n   = 1'b0;
    err_n    = 1'b0;
    case (state)
      IDLE: begin
        dat_oe_n = 1'b0;
        cnt_n    = '0;
        if (tx_valid && tx_ready) begin
          byte_n   = tx_data;
          par_n    = ~^tx_data;
          state_n  = INHIBIT;
          clk_oe_n = 1'b1;
        end
      end
      INHIBIT: begin
        clk_oe_n = 1'b1;
        // Start bit overlaps the last inhibit cycle so DAT is low before CLK is released.
        if (cnt >= CNT_W'(INHIBIT_CYCLES - 2)) dat_oe_n = 1'b1;
        if (cnt >= CNT_W'(INHIBIT_CYCLES - 1)) begin
          clk_oe_n = 1'b0;
          cnt_n    = '0;
          state_n  = RTS;
        end
      end
      RTS: begin
        dat_oe_n = 1'b1;
        if (fall) begin
          state_n  = DATA;
          idx_n    = 3'd0;
          dat_oe_n = ~byte_q[0];
          cnt_n    = '0;
        end else if (cnt >= CNT_W'(START_TIMEOUT - 1)) begin
          state_n = ERR;
          err_n   = 1'b1;
        end
      end
      DATA: begin
        if (fall) begin
          cnt_n = '0;
          if (idx == 3'd7) begin
            dat_oe_n = ~par_q;
            state_n  = PARITY;
          end else begin
            idx_n    = idx + 3'd1;
            dat_oe_n = ~byte_q[idx + 3'd1];
          end
        end else if (bit_to) begin
          state_n = ERR;
          err_n   = 1'b1;
        end
      end
      PARITY: begin
        if (fall) begin
          cnt_n    = '0;
          dat_oe_n = 1'b0;
          state_n  = STOP;
        end else if (bit_to) begin
          state_n = ERR;
          err_n   = 1'b1;
        end
      end
      STOP: begin
        dat_oe_n = 1'b0;
        if (fall) begin
          cnt_n = '0;
          if (!kbdat_sync) begin
            state_n = WAIT_IDLE;
          end else begin
            state_n = ERR;
            err_n   = 1'b1;
          end
        end else if (bit_to) begin
          state_n = ERR;
          err_n   = 1'b1;
        end
      end
      WAIT_IDLE: begin
        dat_oe_n = 1'b0;
        if (fall) cnt_n = '0;
        if (kbclk_sync && kbdat_sync) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else if (bit_to) begin
          state_n = ERR;
          err_n   = 1'b1;
        end
      end
      ERR: begin
        dat_oe_n = 1'b0;
        state_n  = IDLE;
      end
      default: begin
        dat_oe_n = 1'b0;
        state_n  = IDLE;
      end
    endcase
    if (err_n) dat_oe_n = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= 3'd0;
      byte_q       <= 8'd0;
      par_q        <= 1'b0;
      tx_ready     <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      PS2_KBCLK_OE <= 1'b0;
      PS2_KBDAT_OE <= 1'b0;
      kbclk_meta   <= 1'b1;
      kbclk_sync   <= 1'b1;
      kbclk_sync_d <= 1'b1;
      kbdat_meta   <= 1'b1;
      kbdat_sync   <= 1'b1;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      idx          <= idx_n;
      byte_q       <= byte_n;
      par_q        <= par_n;
      tx_ready     <= (state_n == IDLE);
      busy         <= (state_n != IDLE);
      done         <= done_n;
      err          <= err_n;
      PS2_KBCLK_OE <= clk_oe_n;
      PS2_KBDAT_OE <= dat_oe_n;
      kbclk_meta   <= PS2_KBCLK_IN;
      kbclk_sync   <= kbclk_meta;
      kbclk_sync_d <= kbclk_sync;
      kbdat_meta   <= PS2_KBDAT_IN;
      kbdat_sync   <= kbdat_meta;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus plus a PS/2 device model and a frame-level reference.
module tb_ps2_host_tx;

  localparam int unsigned INH = 8;
  localparam int unsigned ST  = 200;
  localparam int unsigned BT  = 100;
  // Pin edge to registered reaction: two synchronizer flops plus the state register.
  localparam int unsigned SYNC_LAT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'd0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, done, err, clk_oe, dat_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       kbclk_pin, kbdat_pin;

  assign kbclk_pin = ~(clk_oe | dev_clk_low);
  assign kbdat_pin = ~(dat_oe | dev_dat_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .START_TIMEOUT(ST), .BIT_TIMEOUT(BT)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .done(done), .err(err),
    .PS2_KBCLK_IN(kbclk_pin), .PS2_KBDAT_IN(kbdat_pin),
    .PS2_KBCLK_OE(clk_oe), .PS2_KBDAT_OE(dat_oe)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0, cyc = 0;
  int done_cnt = 0, err_cnt = 0, done_cyc = 0, err_cyc = 0;
  int base_done = 0, base_err = 0, rel_cyc = 0, last_fall = 0;
  bit scramble = 1'b0;
  logic [10:0] samp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame as seen by the device: start, 8 data bits LSB first, odd parity, stop.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    logic [10:0] f;
    int ones;
    ones = 0;
    f = '0;
    for (int k = 0; k < 8; k++) begin
      f[k+1] = b[k];
      ones += int'(b[k]);
    end
    f[9]  = ((ones % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic cyc_check();
    check("ready_vs_busy", tx_ready, !busy);
    check("done_err_exclusive", done & err, 0);
    if (!busy) check("idle_lines_released", {clk_oe, dat_oe}, 0);
    if (err) check("err_lines_released", {clk_oe, dat_oe}, 0);
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (err) begin err_cnt++; err_cyc = cyc; end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      if (scramble) tx_data = 8'($urandom);
      cyc_check();
    end
  endtask

  task automatic accept(input logic [7:0] b, input bit hold);
    int k;
    k = 0;
    while (!tx_ready && k < 1000) begin tick(1); k++; end
    check("ready_wait", tx_ready, 1);
    base_done = done_cnt;
    base_err  = err_cnt;
    tx_data  = b;
    tx_valid = 1'b1;
    tick(1);
    if (!hold) tx_valid = 1'b0;
    check("busy_after_accept", busy, 1);
    check("clk_low_after_accept", clk_oe, 1);
  endtask

  task automatic inhibit_phase();
    int n;
    bit saw_start;
    n = 0;
    saw_start = 1'b0;
    while (clk_oe && n < 100) begin
      if (dat_oe) saw_start = 1'b1;
      n++;
      tick(1);
    end
    check("inhibit_len", n, INH);
    check("start_before_release", saw_start, 1);
    check("start_bit_at_release", dat_oe, 1);
    rel_cyc = cyc;
  endtask

  // Device: sample DAT in the high phase, then a 20-low/20-high clock (40 cycles).
  task automatic dev_clock(input int nfalls, input bit ack);
    samp = '0;
    for (int i = 0; i < nfalls; i++) begin
      tick(10);
      samp[i] = kbdat_pin;
      if (i == 10 && ack) dev_dat_low = 1'b1;
      tick(10);
      dev_clk_low = 1'b1;
      last_fall = cyc;
      tick(20);
      dev_clk_low = 1'b0;
    end
    if (ack) begin
      tick(5);
      dev_dat_low = 1'b0;
    end
  endtask

  task automatic check_frame(input logic [7:0] b, input int n);
    logic [10:0] f;
    f = model_frame(b);
    for (int i = 0; i < n; i++)
      check($sformatf("frame_%02h_bit%0d", b, i), samp[i], f[i]);
  endtask

  task automatic wait_pulse(input int bound);
    int k;
    k = 0;
    while (done_cnt == base_done && err_cnt == base_err && k < bound) begin tick(1); k++; end
    check("outcome_seen", (done_cnt != base_done) || (err_cnt != base_err), 1);
  endtask

  task automatic check_outcome(input bit exp_done);
    check("done_count", done_cnt - base_done, exp_done ? 1 : 0);
    check("err_count", err_cnt - base_err, exp_done ? 0 : 1);
  endtask

  // mode 0: ACK, 1: no ACK, 2: device never clocks, 3: device stalls after nf falls.
  task automatic xfer(input logic [7:0] b, input int mode, input int nf);
    accept(b, 1'b0);
    inhibit_phase();
    case (mode)
      0: begin
        dev_clock(11, 1'b1);
        check_frame(b, 11);
        wait_pulse(300);
        check_outcome(1'b1);
        tick(1);
        check("ready_after_done", tx_ready, 1);
      end
      1: begin
        dev_clock(11, 1'b0);
        check_frame(b, 11);
        wait_pulse(300);
        check_outcome(1'b0);
      end
      2: begin
        wait_pulse(ST + 50);
        check_outcome(1'b0);
        check("start_timeout_cycles", err_cyc - rel_cyc, ST);
      end
      default: begin
        dev_clock(nf, 1'b0);
        check_frame(b, nf);
        wait_pulse(BT + 50);
        check_outcome(1'b0);
        check("bit_timeout_cycles", err_cyc - last_fall, BT + SYNC_LAT);
      end
    endcase
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] f;
    logic [7:0]  rb;
    tick(3);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done_err", {done, err}, 0);
    check("rst_oe", {clk_oe, dat_oe}, 0);
    rst = 1'b0;
    tick(2);

    check("model_ed", model_frame(8'hED), 11'h7DA);
    check("model_ff", model_frame(8'hFF), 11'h7FE);
    check("model_00", model_frame(8'h00), 11'h600);

    xfer(8'hED, 0, 0);
    check("ed_sampled_literal", samp, 11'h7DA);
    xfer(8'hFF, 1, 0);
    check("ff_sampled_literal", samp, 11'h7FE);
    xfer(8'h00, 2, 0);
    xfer(8'h5A, 3, 4);

    // Reset while bit 5 is on the line.
    accept(8'h3C, 1'b0);
    inhibit_phase();
    dev_clock(6, 1'b0);
    f = model_frame(8'h3C);
    check("bit5_on_line", kbdat_pin, f[6]);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rst_mid_oe", {clk_oe, dat_oe}, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_ready", tx_ready, 1);
    check("rst_mid_done_err", {done, err}, 0);
    tick(ST + BT);
    check("rst_mid_no_done", done_cnt - base_done, 0);
    check("rst_mid_no_err", err_cnt - base_err, 0);
    xfer(8'hF4, 0, 0);

    // tx_valid held with tx_data changing: only the latched byte goes out.
    accept(8'hA5, 1'b1);
    scramble = 1'b1;
    inhibit_phase();
    dev_clock(11, 1'b1);
    check_frame(8'hA5, 11);
    wait_pulse(300);
    check_outcome(1'b1);
    begin
      int k;
      k = 0;
      while (!busy && k < 4) begin tick(1); k++; end
    end
    check("second_accept_after_done", busy, 1);
    tx_valid = 1'b0;
    scramble = 1'b0;
    base_done = done_cnt;
    base_err  = err_cnt;
    inhibit_phase();
    wait_pulse(ST + 50);
    check_outcome(1'b0);

    for (int r = 0; r < 12; r++) begin
      rb = 8'($urandom);
      xfer(rb, int'($urandom_range(0, 3)), int'($urandom_range(1, 10)));
    end

    tick(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
